// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Encodings shared by the ID-stage ALU control decoder, the forwarding unit
//   and the EX stage.
//   - ALU_* : 3-bit alu_ctrl codes (must match the decoder bit-for-bit)
//   - FWD_* : 2-bit forwarding-mux selects (2'b11 is treated as FWD_REG)
//   - ex_ctrl_t : MEM/WB control bits carried through EX/MEM
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ex_ctrl_t;

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
//   Purely combinational MIPS ALU.
//   Ports:
//     a, b      in   DATA_W  operands (for sll, b is the shifted value)
//     shamt     in   5       shift amount for sll
//     alu_ctrl  in   3       operation code (mips_pkg::ALU_*)
//     result    out  DATA_W  operation result
//     zero      out  1       result == 0
// ----------------------------------------------------------------------------
module alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        // NOTE: result gets a default before the case so no path leaves it
        // unassigned; a missing assignment in always_comb infers a latch.
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLL: result = b << shamt;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
//   Execute stage of the 5-stage MIPS pipeline: operand forwarding muxes,
//   ALU, branch-target adder and the EX/MEM pipeline register.
//   Ports:
//     clk, rst            clock, async active-high reset
//     stall, flush        EX/MEM hold / bubble insert (flush wins)
//     in_valid            ID/EX holds a real instruction
//     alu_ctrl, shamt     ALU operation and sll shift amount
//     rs_data, rt_data,   ID/EX operands and sign-extended immediate
//     imm_ext, alu_src
//     fwd_a, fwd_b,       forwarding selects and forwarded values
//     fwd_mem_data,
//     fwd_wb_data
//     pc_plus4, rd_dst    PC+4 and destination register
//     reg_write..branch   MEM/WB control passed through
//     exm_*               registered EX/MEM outputs
// ----------------------------------------------------------------------------
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [4:0]        shamt,
    input  logic              alu_src,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [REG_AW-1:0] rd_dst,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              branch,
    output logic              exm_valid,
    output logic [DATA_W-1:0] exm_alu_result,
    output logic              exm_zero,
    output logic [DATA_W-1:0] exm_branch_tgt,
    output logic [DATA_W-1:0] exm_store_data,
    output logic [REG_AW-1:0] exm_rd,
    output logic              exm_reg_write,
    output logic              exm_mem_read,
    output logic              exm_mem_write,
    output logic              exm_mem_to_reg,
    output logic              exm_branch
);

    // Select 2'b11 falls into the default arm and so behaves like FWD_REG.
    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_v,
        input logic [DATA_W-1:0] mem_v,
        input logic [DATA_W-1:0] wb_v
    );
        case (sel)
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            default: return reg_v;
        endcase
    endfunction

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_bf;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_zero;
    logic [DATA_W-1:0] w_branch_tgt;
    ex_ctrl_t          w_ctrl_in;

    assign w_op_a  = fwd_mux(fwd_a, rs_data, fwd_mem_data, fwd_wb_data);
    assign w_op_bf = fwd_mux(fwd_b, rt_data, fwd_mem_data, fwd_wb_data);
    assign w_op_b  = alu_src ? imm_ext : w_op_bf;

    // sll always shifts the forwarded rt value, independent of alu_src.
    assign w_alu_b = (alu_ctrl == ALU_SLL) ? w_op_bf : w_op_b;

    assign w_branch_tgt = pc_plus4 + (imm_ext << 2);
    assign w_ctrl_in    = {reg_write, mem_read, mem_write, mem_to_reg, branch};

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (w_op_a),
        .b        (w_alu_b),
        .shamt    (shamt),
        .alu_ctrl (alu_ctrl),
        .result   (w_alu_result),
        .zero     (w_alu_zero)
    );

    // ------------------------------------------------------------------------
    // EX/MEM register: rst > flush > stall > load
    // ------------------------------------------------------------------------
    logic              r_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic              r_zero;
    logic [DATA_W-1:0] r_branch_tgt;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_rd;
    ex_ctrl_t          r_ctrl;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_zero       <= 1'b0;
            r_branch_tgt <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_zero       <= 1'b0;
            r_branch_tgt <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
        end else if (!stall) begin
            r_valid      <= in_valid;
            r_alu_result <= w_alu_result;
            r_zero       <= w_alu_zero;
            r_branch_tgt <= w_branch_tgt;
            r_store_data <= w_op_bf;
            r_rd         <= rd_dst;
            // A bubble must never carry a live write-enable into MEM/WB.
            r_ctrl       <= in_valid ? w_ctrl_in : '0;
        end
    end

    assign exm_valid      = r_valid;
    assign exm_alu_result = r_alu_result;
    assign exm_zero       = r_zero;
    assign exm_branch_tgt = r_branch_tgt;
    assign exm_store_data = r_store_data;
    assign exm_rd         = r_rd;
    assign exm_reg_write  = r_ctrl.reg_write;
    assign exm_mem_read   = r_ctrl.mem_read;
    assign exm_mem_write  = r_ctrl.mem_write;
    assign exm_mem_to_reg = r_ctrl.mem_to_reg;
    assign exm_branch     = r_ctrl.branch;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
//   Directed vectors with hand-computed expectations. The driver sets inputs
//   on the falling edge and queues the EX/MEM contents expected after the
//   next rising edge; an independent monitor pops and compares one entry
//   shortly after each rising edge.
// ----------------------------------------------------------------------------
module tb_ex_stage;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // valid, result, zero, branch_tgt, store_data, rd, {rw, mr, mw, m2r, br}
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] tgt;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] rd;
        logic [4:0]        ctrl;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall, flush, in_valid, alu_src;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] rs_data, rt_data, imm_ext, fwd_mem_data, fwd_wb_data, pc_plus4;
    logic [4:0]        shamt;
    logic [1:0]        fwd_a, fwd_b;
    logic [REG_AW-1:0] rd_dst;
    logic              reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic              exm_valid, exm_zero;
    logic [DATA_W-1:0] exm_alu_result, exm_branch_tgt, exm_store_data;
    logic [REG_AW-1:0] exm_rd;
    logic              exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg, exm_branch;

    int   checks   = 0;
    int   failures = 0;
    sb_t  sb_q[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .alu_ctrl       (alu_ctrl),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .imm_ext        (imm_ext),
        .shamt          (shamt),
        .alu_src        (alu_src),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .fwd_mem_data   (fwd_mem_data),
        .fwd_wb_data    (fwd_wb_data),
        .pc_plus4       (pc_plus4),
        .rd_dst         (rd_dst),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .branch         (branch),
        .exm_valid      (exm_valid),
        .exm_alu_result (exm_alu_result),
        .exm_zero       (exm_zero),
        .exm_branch_tgt (exm_branch_tgt),
        .exm_store_data (exm_store_data),
        .exm_rd         (exm_rd),
        .exm_reg_write  (exm_reg_write),
        .exm_mem_read   (exm_mem_read),
        .exm_mem_write  (exm_mem_write),
        .exm_mem_to_reg (exm_mem_to_reg),
        .exm_branch     (exm_branch)
    );

    function automatic exp_t act_out();
        exp_t a;
        a = {exm_valid, exm_alu_result, exm_zero, exm_branch_tgt, exm_store_data, exm_rd,
             exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg, exm_branch};
        return a;
    endfunction

    function automatic exp_t mk(input logic v, input logic [DATA_W-1:0] res, input logic z,
                                input logic [DATA_W-1:0] tgt, input logic [DATA_W-1:0] st,
                                input logic [REG_AW-1:0] rd, input logic [4:0] ctrl);
        exp_t e;
        e = {v, res, z, tgt, st, rd, ctrl};
        return e;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got v=%b res=%h z=%b tgt=%h st=%h rd=%0d ctrl=%b, want v=%b res=%h z=%b tgt=%h st=%h rd=%0d ctrl=%b",
                     name, act.valid, act.result, act.zero, act.tgt, act.store, act.rd, act.ctrl,
                     exp.valid, exp.result, exp.zero, exp.tgt, exp.store, exp.rd, exp.ctrl);
        end
    endtask

    task automatic clear_in();
        stall = 0; flush = 0; in_valid = 0; alu_src = 0; alu_ctrl = ALU_AND;
        rs_data = '0; rt_data = '0; imm_ext = '0; fwd_mem_data = '0; fwd_wb_data = '0;
        pc_plus4 = '0; shamt = '0; fwd_a = FWD_REG; fwd_b = FWD_REG; rd_dst = '0;
        reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; branch = 0;
    endtask

    task automatic expect_out(input string name, input exp_t e);
        sb_t s;
        s.name = name;
        s.e    = e;
        sb_q.push_back(s);
        last_exp = e;
    endtask

    // Monitor: compares EX/MEM contents 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                sb_t s;
                s = sb_q.pop_front();
                check(s.name, act_out(), s.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        repeat (2) @(negedge clk);
        check("reset_state", act_out(), '0);

        // add
        rst = 0; clear_in();
        in_valid = 1; alu_ctrl = ALU_ADD; rs_data = 7; rt_data = 5; rd_dst = 3; reg_write = 1;
        expect_out("add", mk(1, 32'd12, 0, '0, 32'd5, 5'd3, 5'b10000));

        // beq-style sub with branch target
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_SUB; rs_data = 32'h1234; rt_data = 32'h1234;
        imm_ext = 32'hFFFF_FFFE; pc_plus4 = 32'h100; branch = 1;
        expect_out("beq_sub", mk(1, '0, 1, 32'hF8, 32'h1234, 5'd0, 5'b00001));

        // slt with A forwarded from EX/MEM
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_SLT; fwd_a = FWD_MEM; fwd_mem_data = 32'hFFFF_FFFF;
        rs_data = 0; rt_data = 1; rd_dst = 4; reg_write = 1;
        expect_out("slt_fwd_mem", mk(1, 32'd1, 0, '0, 32'd1, 5'd4, 5'b10000));

        // plus B forwarded from MEM/WB
        @(negedge clk);
        fwd_b = FWD_WB; fwd_wb_data = '0;
        expect_out("slt_fwd_wb", mk(1, 32'd1, 0, '0, '0, 5'd4, 5'b10000));

        // select 11 behaves like 00
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_ADD; fwd_a = 2'b11; fwd_b = 2'b11; rs_data = 5; rt_data = 3;
        fwd_mem_data = 32'd100; fwd_wb_data = 32'd200;
        expect_out("fwd_11", mk(1, 32'd8, 0, '0, 32'd3, 5'd0, 5'b00000));

        // bitwise ops
        @(negedge clk); clear_in();
        in_valid = 1; rs_data = 32'hF0F0_F0F0; rt_data = 32'h0FF0_0FF0; alu_ctrl = ALU_AND;
        expect_out("and", mk(1, 32'h00F0_00F0, 0, '0, 32'h0FF0_0FF0, 5'd0, 5'b0));
        @(negedge clk); alu_ctrl = ALU_XOR;
        expect_out("xor", mk(1, 32'hFF00_FF00, 0, '0, 32'h0FF0_0FF0, 5'd0, 5'b0));
        @(negedge clk); alu_ctrl = ALU_NOR;
        expect_out("nor", mk(1, 32'h000F_000F, 0, '0, 32'h0FF0_0FF0, 5'd0, 5'b0));
        @(negedge clk); alu_ctrl = ALU_OR;
        expect_out("or", mk(1, 32'hFFF0_FFF0, 0, '0, 32'h0FF0_0FF0, 5'd0, 5'b0));

        // sll shifts rt, not rs
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_SLL; rs_data = 32'hDEAD; rt_data = 1; shamt = 31;
        expect_out("sll", mk(1, 32'h8000_0000, 0, '0, 32'd1, 5'd0, 5'b0));

        // sub wraps
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_SUB; rs_data = 0; rt_data = 1;
        expect_out("sub_wrap", mk(1, 32'hFFFF_FFFF, 0, '0, 32'd1, 5'd0, 5'b0));

        // slti: 5 < -1 is false; store data stays rt
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_SLT; alu_src = 1; rs_data = 5; imm_ext = 32'hFFFF_FFFF;
        rt_data = 32'h77;
        expect_out("slti", mk(1, '0, 1, 32'hFFFF_FFFC, 32'h77, 5'd0, 5'b0));

        // lw, then three stall cycles with different inputs
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_ADD; alu_src = 1; rs_data = 32'h2000; imm_ext = 4;
        rt_data = 32'h55; rd_dst = 9; reg_write = 1; mem_read = 1; mem_to_reg = 1;
        expect_out("lw", mk(1, 32'h2004, 0, 32'h10, 32'h55, 5'd9, 5'b11010));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1; rs_data = 32'hBAD0 + i; rt_data = 32'h1111; rd_dst = 5'd30 - 5'(i);
            mem_read = 0; mem_write = 1; branch = 1;
            expect_out("stall_hold", last_exp);
        end

        // flush beats stall
        @(negedge clk);
        stall = 1; flush = 1;
        expect_out("flush_over_stall", '0);

        // in_valid=0 load is a bubble that still captures data
        @(negedge clk); clear_in();
        in_valid = 0; alu_ctrl = ALU_ADD; rs_data = 3; rt_data = 4; rd_dst = 2;
        reg_write = 1; mem_write = 1;
        expect_out("bubble", mk(0, 32'd7, 0, '0, 32'd4, 5'd2, 5'b0));

        // async reset mid-cycle with live data
        @(negedge clk); clear_in();
        in_valid = 1; alu_ctrl = ALU_ADD; rs_data = 32'h11; rt_data = 32'h22; rd_dst = 7;
        reg_write = 1;
        expect_out("live", mk(1, 32'h33, 0, '0, 32'h22, 5'd7, 5'b10000));
        @(posedge clk);
        #3 rst = 1;
        #1 check("async_rst", act_out(), '0);

        // sw after reset release, rt forwarded from EX/MEM
        @(negedge clk); rst = 0; clear_in();
        in_valid = 1; alu_ctrl = ALU_ADD; alu_src = 1; rs_data = 32'h1000; imm_ext = 8;
        rt_data = 32'h99; fwd_b = FWD_MEM; fwd_mem_data = 32'hCAFE; mem_write = 1;
        expect_out("sw", mk(1, 32'h1008, 0, 32'h20, 32'hCAFE, 5'd0, 5'b00100));

        // idle bubble: 0 & 0 = 0 so zero is set
        @(negedge clk); clear_in();
        expect_out("idle", mk(0, '0, 1, '0, '0, 5'd0, 5'b0));

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
